// File: rtl/logic_grid_pkg.sv
// logic_grid_pkg: shared types and sizing helpers for the logic grid loader.
//   state_e       : loader FSM states (READBACK is only reachable when
//                   CFG_READBACK_EN is defined)
//   calc_words    : number of stream words needed to carry a config image
//   calc_chain_w  : width of the internal shift chain (whole words)
package logic_grid_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CHECK    = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4,
    READBACK = 3'd5
  } state_e;

  function automatic int calc_words(input int total, input int word_w);
    return (total + word_w - 1) / word_w;
  endfunction

  function automatic int calc_chain_w(input int total, input int word_w);
    return calc_words(total, word_w) * word_w;
  endfunction

endpackage

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serial configuration loader with trailing XOR checksum.
//   cfg_start/cfg_data/cfg_valid/cfg_ready : config word stream
//   cfg_done / cfg_error                   : load status
//   cfg_bits                               : TOTAL config bits (padding dropped)
//   fabric_hold                            : high whenever state != DONE
// Optional macro CFG_READBACK_EN adds rb_start/rb_data/rb_valid/rb_ready and
// a READBACK state that rotates the chain out word by word and restores it.
module cfg_chain_loader
  import logic_grid_pkg::*;
#(
  parameter int TOTAL      = 1746,
  parameter int CFG_WORD_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [CFG_WORD_W-1:0] cfg_data,
  input  logic                  cfg_valid,
`ifdef CFG_READBACK_EN
  input  logic                  rb_start,
  output logic [CFG_WORD_W-1:0] rb_data,
  output logic                  rb_valid,
  input  logic                  rb_ready,
`endif
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_error,
  output logic [TOTAL-1:0]      cfg_bits,
  output logic                  fabric_hold
);

  localparam int WORDS   = calc_words(TOTAL, CFG_WORD_W);
  localparam int CHAIN_W = calc_chain_w(TOTAL, CFG_WORD_W);
  localparam int CNT_W   = $clog2(WORDS + 1);

  state_e                state_q, state_d;
  logic [CHAIN_W-1:0]    chain_q, chain_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CFG_WORD_W-1:0] csum_q, csum_d;
  logic                  xfer, last_word;

  assign xfer      = cfg_valid && cfg_ready;
  assign last_word = (cnt_q == CNT_W'(WORDS - 1));
  assign cfg_bits  = chain_q[TOTAL-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      chain_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    // A restart wins over any word presented in the same cycle.
    if (cfg_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        LOAD: if (xfer) begin
          chain_d = {cfg_data, chain_q[CHAIN_W-1:CFG_WORD_W]};
          csum_d  = csum_q ^ cfg_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_word) state_d = CHECK;
        end
        CHECK: if (xfer) state_d = (cfg_data == csum_q) ? DONE : ERROR;
`ifdef CFG_READBACK_EN
        DONE: if (rb_start) begin
          state_d = READBACK;
          cnt_d   = '0;
        end
        READBACK: if (rb_valid && rb_ready) begin
          chain_d = {chain_q[CFG_WORD_W-1:0], chain_q[CHAIN_W-1:CFG_WORD_W]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_word) state_d = DONE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_ready   = 1'b0;
    cfg_done    = 1'b0;
    cfg_error   = 1'b0;
    fabric_hold = 1'b1;
`ifdef CFG_READBACK_EN
    rb_valid    = 1'b0;
    rb_data     = '0;
`endif
    case (state_q)
      LOAD, CHECK: cfg_ready = 1'b1;
      DONE: begin
        cfg_done    = 1'b1;
        fabric_hold = 1'b0;
      end
      ERROR: cfg_error = 1'b1;
`ifdef CFG_READBACK_EN
      READBACK: begin
        rb_valid = 1'b1;
        rb_data  = chain_q[CFG_WORD_W-1:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/logic_column.sv
// logic_column: one column of the logic fabric.
//   config_in          : COL_CFG_W configuration bits
//   north/south in/out : NS_IO_PER_COL bits each
//   east/west in/out   : EW_IO bits each
//   reset              : held high while the fabric is not configured
// East and west outputs are the opposite-side inputs masked by a fold of the
// whole config word; north_out is combinational, south_out is registered.
module logic_column #(
  parameter int COL_CFG_W     = 582,
  parameter int NS_IO_PER_COL = 6,
  parameter int EW_IO         = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COL_CFG_W-1:0]     config_in,
  input  logic [NS_IO_PER_COL-1:0] north_in,
  output logic [NS_IO_PER_COL-1:0] north_out,
  input  logic [NS_IO_PER_COL-1:0] south_in,
  output logic [NS_IO_PER_COL-1:0] south_out,
  input  logic [EW_IO-1:0]         east_in,
  output logic [EW_IO-1:0]         east_out,
  input  logic [EW_IO-1:0]         west_in,
  output logic [EW_IO-1:0]         west_out
);

  function automatic logic [EW_IO-1:0] fold_cfg(input logic [COL_CFG_W-1:0] c);
    logic [EW_IO-1:0] f;
    f = '0;
    for (int i = 0; i < COL_CFG_W; i++) f[i % EW_IO] ^= c[i];
    return f;
  endfunction

  logic [EW_IO-1:0]         cfg_fold;
  logic [NS_IO_PER_COL-1:0] north_d, north_q;

  assign cfg_fold = fold_cfg(config_in);

  always_comb north_d = north_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) north_q <= '0;
    else       north_q <= north_d;
  end

  assign east_out  = west_in ^ cfg_fold;
  assign west_out  = east_in ^ cfg_fold;
  assign north_out = south_in ^ config_in[NS_IO_PER_COL-1:0];
  assign south_out = north_q ^ config_in[2*NS_IO_PER_COL-1:NS_IO_PER_COL];

endmodule

// File: rtl/logic_grid_loader.sv
// logic_grid_loader: NUM_COLUMNS logic columns chained west (0) to east, fed
// by an on-chip serial config loader.
//   data_north/south_* : column c uses [c*NS_IO_PER_COL +: NS_IO_PER_COL]
//   data_west_*        : column 0 west side;  data_east_* : last column east side
//   cfg_*              : config stream and status (see cfg_chain_loader)
// Columns are held in reset and all data outputs forced to 0 until a load
// passes its checksum. Optional macro CFG_READBACK_EN adds rb_* readback ports.
module logic_grid_loader
  import logic_grid_pkg::*;
#(
  parameter int NUM_COLUMNS   = 3,
  parameter int NS_IO_PER_COL = 6,
  parameter int EW_IO         = 18,
  parameter int COL_CFG_W     = 582,
  parameter int CFG_WORD_W    = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_COLUMNS*NS_IO_PER_COL-1:0] data_north_in,
  output logic [NUM_COLUMNS*NS_IO_PER_COL-1:0] data_north_out,
  input  logic [NUM_COLUMNS*NS_IO_PER_COL-1:0] data_south_in,
  output logic [NUM_COLUMNS*NS_IO_PER_COL-1:0] data_south_out,
  input  logic [EW_IO-1:0]                     data_east_in,
  output logic [EW_IO-1:0]                     data_east_out,
  input  logic [EW_IO-1:0]                     data_west_in,
  output logic [EW_IO-1:0]                     data_west_out,
  input  logic                                 cfg_start,
  input  logic [CFG_WORD_W-1:0]                cfg_data,
  input  logic                                 cfg_valid,
`ifdef CFG_READBACK_EN
  input  logic                                 rb_start,
  output logic [CFG_WORD_W-1:0]                rb_data,
  output logic                                 rb_valid,
  input  logic                                 rb_ready,
`endif
  output logic                                 cfg_ready,
  output logic                                 cfg_done,
  output logic                                 cfg_error
);

  localparam int TOTAL = NUM_COLUMNS * COL_CFG_W;
  localparam int NS_W  = NUM_COLUMNS * NS_IO_PER_COL;

  logic [TOTAL-1:0]                  cfg_bits;
  logic                              fabric_hold;
  logic                              col_reset;
  // east_link[c] feeds column c's west_in; west_link[c+1] feeds its east_in.
  logic [NUM_COLUMNS:0][EW_IO-1:0]   east_link, west_link;
  logic [NS_W-1:0]                   north_col, south_col;

  cfg_chain_loader #(
    .TOTAL      (TOTAL),
    .CFG_WORD_W (CFG_WORD_W)
  ) u_loader (
    .clock       (clock),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
`ifdef CFG_READBACK_EN
    .rb_start    (rb_start),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid),
    .rb_ready    (rb_ready),
`endif
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .cfg_bits    (cfg_bits),
    .fabric_hold (fabric_hold)
  );

  assign col_reset                = reset | fabric_hold;
  assign east_link[0]             = data_west_in;
  assign west_link[NUM_COLUMNS]   = data_east_in;

  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
    logic_column #(
      .COL_CFG_W     (COL_CFG_W),
      .NS_IO_PER_COL (NS_IO_PER_COL),
      .EW_IO         (EW_IO)
    ) u_col (
      .clock     (clock),
      .reset     (col_reset),
      .config_in (cfg_bits[c*COL_CFG_W +: COL_CFG_W]),
      .north_in  (data_north_in[c*NS_IO_PER_COL +: NS_IO_PER_COL]),
      .north_out (north_col[c*NS_IO_PER_COL +: NS_IO_PER_COL]),
      .south_in  (data_south_in[c*NS_IO_PER_COL +: NS_IO_PER_COL]),
      .south_out (south_col[c*NS_IO_PER_COL +: NS_IO_PER_COL]),
      .east_in   (west_link[c+1]),
      .east_out  (east_link[c+1]),
      .west_in   (east_link[c]),
      .west_out  (west_link[c])
    );
  end

  assign data_north_out = fabric_hold ? '0 : north_col;
  assign data_south_out = fabric_hold ? '0 : south_col;
  assign data_east_out  = fabric_hold ? '0 : east_link[NUM_COLUMNS];
  assign data_west_out  = fabric_hold ? '0 : west_link[0];

endmodule

// File: tb/tb_logic_grid_loader.sv
// Bench for logic_grid_loader: a small instance (1 column, 40 cfg bits,
// 16-bit words) for the directed vectors and a default-parameter instance
// fed random streams. Expected load outcomes are queued by the drivers and
// checked by per-instance monitors when cfg_done or cfg_error rises.
module tb_logic_grid_loader;
  import logic_grid_pkg::*;

  localparam int S_TOT = 40, S_W = 16;
  localparam int D_N = 3, D_CW = 582, D_W = 32, D_TOT = 1746, D_WORDS = 55;
  localparam int NS = 6, EW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Fold a column config into EW bits: XOR of consecutive EW-bit chunks.
  function automatic logic [EW-1:0] fold(input logic [D_CW-1:0] c);
    logic [D_CW+EW-1:0] t;
    logic [EW-1:0] f;
    t = {{EW{1'b0}}, c};
    f = '0;
    for (int k = 0; k < (D_CW + EW - 1) / EW; k++) begin
      f ^= t[EW-1:0];
      t = t >> EW;
    end
    return f;
  endfunction

  // ---------------- small instance ----------------
  logic rst_s;
  logic s_start, s_valid, s_ready, s_done, s_err;
  logic [S_W-1:0] s_data;
  logic [NS-1:0] s_ni, s_no, s_si, s_so;
  logic [EW-1:0] s_ei, s_eo, s_wi, s_wo;
`ifdef CFG_READBACK_EN
  logic s_rb_start, s_rb_valid, s_rb_ready;
  logic [S_W-1:0] s_rb_data;
  logic d_rb_valid;
  logic [D_W-1:0] d_rb_data;
`endif

  logic_grid_loader #(.NUM_COLUMNS(1), .COL_CFG_W(S_TOT), .CFG_WORD_W(S_W)) dut_s (
    .clock(clk), .reset(rst_s),
    .data_north_in(s_ni), .data_north_out(s_no),
    .data_south_in(s_si), .data_south_out(s_so),
    .data_east_in(s_ei), .data_east_out(s_eo),
    .data_west_in(s_wi), .data_west_out(s_wo),
    .cfg_start(s_start), .cfg_data(s_data), .cfg_valid(s_valid),
`ifdef CFG_READBACK_EN
    .rb_start(s_rb_start), .rb_data(s_rb_data), .rb_valid(s_rb_valid), .rb_ready(s_rb_ready),
`endif
    .cfg_ready(s_ready), .cfg_done(s_done), .cfg_error(s_err)
  );

  // ---------------- default instance ----------------
  logic rst_d;
  logic d_start, d_valid, d_ready, d_done, d_err;
  logic [D_W-1:0] d_data;
  logic [D_N*NS-1:0] d_ni, d_no, d_si, d_so;
  logic [EW-1:0] d_ei, d_eo, d_wi, d_wo;

  logic_grid_loader dut_d (
    .clock(clk), .reset(rst_d),
    .data_north_in(d_ni), .data_north_out(d_no),
    .data_south_in(d_si), .data_south_out(d_so),
    .data_east_in(d_ei), .data_east_out(d_eo),
    .data_west_in(d_wi), .data_west_out(d_wo),
    .cfg_start(d_start), .cfg_data(d_data), .cfg_valid(d_valid),
`ifdef CFG_READBACK_EN
    .rb_start(1'b0), .rb_data(d_rb_data), .rb_valid(d_rb_valid), .rb_ready(1'b0),
`endif
    .cfg_ready(d_ready), .cfg_done(d_done), .cfg_error(d_err)
  );

  typedef struct { bit done; bit err; logic [S_TOT-1:0] cfg; } s_exp_t;
  typedef struct { bit done; bit err; logic [D_TOT-1:0] cfg; } d_exp_t;
  s_exp_t s_q[$];
  d_exp_t d_q[$];

  // ---------------- monitors ----------------
  initial begin : mon_s
    bit prev, cur;
    s_exp_t e;
    logic [EW-1:0] f;
    prev = 0;
    forever begin
      @(negedge clk);
      cur = s_done || s_err;
      if (cur && !prev) begin
        if (s_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected_status got done=%0b err=%0b exp none", s_done, s_err);
        end else begin
          e = s_q.pop_front();
          chk("s_done", s_done, e.done);
          chk("s_err", s_err, e.err);
          chk("s_cfg", dut_s.cfg_bits, e.cfg);
          if (e.done) begin
            f = fold(D_CW'(e.cfg));
            chk("s_north_out", s_no, s_si ^ e.cfg[NS-1:0]);
            chk("s_east_out", s_eo, s_wi ^ f);
            chk("s_west_out", s_wo, s_ei ^ f);
          end else begin
            chk("s_outs_held", {s_no, s_so, s_eo, s_wo}, 64'h0);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : mon_d
    bit prev, cur;
    d_exp_t e;
    logic [EW-1:0] f;
    int first;
    prev = 0;
    forever begin
      @(negedge clk);
      cur = d_done || d_err;
      if (cur && !prev) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_unexpected_status got done=%0b err=%0b exp none", d_done, d_err);
        end else begin
          e = d_q.pop_front();
          chk("d_done", d_done, e.done);
          chk("d_err", d_err, e.err);
          checks++;
          if (dut_d.cfg_bits !== e.cfg) begin
            errors++;
            first = -1;
            for (int i = D_TOT - 1; i >= 0; i--) if (dut_d.cfg_bits[i] !== e.cfg[i]) first = i;
            $display("FAIL d_cfg first differing bit %0d got=%b exp=%b", first,
                     dut_d.cfg_bits[first], e.cfg[first]);
          end
          if (e.done) begin
            f = '0;
            for (int c = 0; c < D_N; c++) begin
              f ^= fold(e.cfg[c*D_CW +: D_CW]);
              chk($sformatf("d_north_out_col%0d", c), d_no[c*NS +: NS],
                  d_si[c*NS +: NS] ^ e.cfg[c*D_CW +: NS]);
            end
            chk("d_east_out", d_eo, d_wi ^ f);
            chk("d_west_out", d_wo, d_ei ^ f);
          end else begin
            chk("d_ns_held", {d_no, d_so}, 64'h0);
            chk("d_ew_held", {d_eo, d_wo}, 64'h0);
          end
        end
      end
      prev = cur;
    end
  end

  // ---------------- small drivers ----------------
  task automatic s_pulse_start();
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
  endtask

  task automatic s_send(input logic [S_W-1:0] w);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    chk("s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic s_load(input bit do_start, input logic [S_W-1:0] w0, w1, w2, cs);
    s_exp_t e;
    logic [3*S_W-1:0] full;
    bit good;
    full = {w2, w1, w0};
    good = (cs == (w0 ^ w1 ^ w2));
    e.done = good;
    e.err  = !good;
    e.cfg  = full[S_TOT-1:0];
    s_q.push_back(e);
    if (do_start) s_pulse_start();
    s_send(w0);
    s_send(w1);
    s_send(w2);
    chk("s_done_before_csum", s_done, 1'b0);
    s_send(cs);
    chk("s_done_latency", s_done, good);
    chk("s_err_latency", s_err, !good);
  endtask

  // ---------------- default drivers ----------------
  task automatic d_send(input logic [D_W-1:0] w);
    int n;
    bit sent;
    n = 0;
    sent = 0;
    while (!sent && n < 200) begin
      @(negedge clk);
      n++;
      d_valid = 1'($urandom_range(0, 1));
      d_data  = d_valid ? w : $urandom;
      chk("d_ready", d_ready, 1'b1);
      if (d_valid && d_ready) sent = 1;
      @(posedge clk);
      #1 d_valid = 1'b0;
    end
    if (!sent) begin
      checks++; errors++;
      $display("FAIL d_send_timeout got sent=0 exp sent=1");
    end
  endtask

  task automatic d_load(input bit good);
    logic [D_W-1:0] w[D_WORDS];
    logic [D_WORDS*D_W-1:0] full;
    logic [D_W-1:0] cs;
    d_exp_t e;
    cs = '0;
    for (int i = 0; i < D_WORDS; i++) begin
      w[i] = $urandom;
      full[i*D_W +: D_W] = w[i];
      cs ^= w[i];
    end
    if (!good) cs ^= (32'h1 << $urandom_range(0, 31));
    e.done = good;
    e.err  = !good;
    e.cfg  = full[D_TOT-1:0];
    d_q.push_back(e);
    @(negedge clk);
    d_start = 1'b1;
    @(posedge clk);
    #1 d_start = 1'b0;
    for (int i = 0; i < D_WORDS; i++) d_send(w[i]);
    d_send(cs);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [S_W-1:0] r0, r1, r2;
    rst_s = 1'b1; rst_d = 1'b1;
    s_start = 0; s_valid = 0; s_data = '0;
    d_start = 0; d_valid = 0; d_data = '0;
`ifdef CFG_READBACK_EN
    s_rb_start = 0; s_rb_ready = 0;
`endif
    s_ni = NS'($urandom); s_si = NS'($urandom);
    s_ei = EW'($urandom) | 18'h1; s_wi = EW'($urandom) | 18'h2;
    d_ni = {$urandom, $urandom}; d_si = {$urandom, $urandom};
    d_ei = EW'($urandom); d_wi = EW'($urandom);

    #3;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_s_done", s_done, 1'b0);
    chk("rst_s_err", s_err, 1'b0);
    chk("rst_s_outs", {s_no, s_so, s_eo, s_wo}, 64'h0);
    chk("rst_d_status", {d_ready, d_done, d_err}, 3'b000);
    chk("rst_d_ew", {d_eo, d_wo}, 64'h0);
    #9 rst_s = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1'b0);

    // Directed vector, then a bad checksum, then a good reload.
    s_load(1, 16'h1234, 16'hABCD, 16'h00FF, 16'hB906);
    chk("t1_cfg_const", dut_s.cfg_bits, 40'hFF_ABCD_1234);
    s_load(1, 16'h1234, 16'hABCD, 16'h00FF, 16'hB907);
    chk("t2_done_low", s_done, 1'b0);
    s_load(1, 16'h1234, 16'hABCD, 16'h00FF, 16'hB906);
    chk("t2_err_cleared", s_err, 1'b0);

    // Restart with a word presented in the same cycle: that word is dropped.
    s_pulse_start();
    s_send(16'h5A5A);
    s_send(16'hC3C3);
    @(negedge clk);
    s_start = 1'b1; s_valid = 1'b1; s_data = 16'h7777;
    @(posedge clk);
    #1 s_start = 1'b0; s_valid = 1'b0;
    r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom);
    s_load(0, r0, r1, r2, r0 ^ r1 ^ r2);

    // Asynchronous reset from DONE, then from the middle of a load.
    @(negedge clk);
    #2 rst_s = 1'b1;
    #1;
    chk("t5_done_async", s_done, 1'b0);
    chk("t5_outs_async", {s_no, s_so, s_eo, s_wo}, 64'h0);
    @(negedge clk);
    rst_s = 1'b0;
    s_pulse_start();
    s_send(16'h9999);
    @(negedge clk);
    chk("t5_ready_before_rst", s_ready, 1'b1);
    #2 rst_s = 1'b1;
    #1;
    chk("t5_ready_async", s_ready, 1'b0);
    chk("t5_done_async2", s_done, 1'b0);
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    chk("t5_state_idle", dut_s.u_loader.state_q, IDLE);
    chk("t5_chain_zero", dut_s.u_loader.chain_q, 48'h0);
    chk("t5_ready_idle", s_ready, 1'b0);

`ifdef CFG_READBACK_EN
    begin
      s_exp_t e;
      logic [S_W-1:0] rbw[3];
      rbw[0] = 16'h1234; rbw[1] = 16'hABCD; rbw[2] = 16'h00FF;
      s_load(1, rbw[0], rbw[1], rbw[2], 16'hB906);
      e.done = 1; e.err = 0; e.cfg = 40'hFF_ABCD_1234;
      s_q.push_back(e);
      @(negedge clk);
      s_rb_start = 1'b1; s_rb_ready = 1'b1;
      @(posedge clk);
      #1 s_rb_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("rb_valid", s_rb_valid, 1'b1);
        chk($sformatf("rb_data%0d", i), s_rb_data, rbw[i]);
        chk("rb_held", s_done, 1'b0);
      end
      @(negedge clk);
      s_rb_ready = 1'b0;
      chk("rb_back_done", s_done, 1'b1);
      chk("rb_valid_low", s_rb_valid, 1'b0);
      chk("rb_cfg_kept", dut_s.cfg_bits, 40'hFF_ABCD_1234);
    end
`endif

    // Random streams at default parameters.
    d_load(1);
    d_load(0);
    d_load(1);

    repeat (5) @(negedge clk);
    chk("s_queue_empty", s_q.size(), 0);
    chk("d_queue_empty", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_grid_loader.md
Name: logic_grid_loader

Overview:
- Parametrised successor of the fixed 3-column logic grid: NUM_COLUMNS logic_column instances chained east-west, with north/south IO sliced per column.
- Adds an on-chip serial configuration loader. Config words arrive over a valid/ready stream and shift into an internal chain, which drives every column's config_in.
- A trailing XOR checksum word gates release of the fabric: columns stay in reset with outputs forced to 0 until a good load completes.

Parameters:
- NUM_COLUMNS, 3, number of logic_column instances, west (index 0) to east.
- NS_IO_PER_COL, 6, north/south IO bits per column.
- EW_IO, 18, east/west IO bits (column row count times IO per row).
- COL_CFG_W, 582, config bits per column.
- CFG_WORD_W, 32, config stream word width.

Ports:
- clock  in  1  fabric and loader clock.
- reset  in  1  asynchronous, active-high.
- data_north_in  in  NUM_COLUMNS*NS_IO_PER_COL  column c uses slice [c*NS_IO_PER_COL +: NS_IO_PER_COL].
- data_north_out  out  NUM_COLUMNS*NS_IO_PER_COL  same slicing.
- data_south_in  in  NUM_COLUMNS*NS_IO_PER_COL  same slicing.
- data_south_out  out  NUM_COLUMNS*NS_IO_PER_COL  same slicing.
- data_east_in  in  EW_IO  to column NUM_COLUMNS-1.
- data_east_out  out  EW_IO  from column NUM_COLUMNS-1.
- data_west_in  in  EW_IO  to column 0.
- data_west_out  out  EW_IO  from column 0.
- cfg_start  in  1  single-cycle pulse; begins or restarts a load.
- cfg_data  in  CFG_WORD_W  config or checksum word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- cfg_done  out  1  fabric configured and running.
- cfg_error  out  1  last load failed its checksum.

Behaviour:
Derived widths:
- TOTAL = NUM_COLUMNS*COL_CFG_W.
- WORDS = ceil(TOTAL/CFG_WORD_W).
- CHAIN_W = WORDS*CFG_WORD_W.

Reset:
- State IDLE; chain, word counter and checksum register all 0.
- cfg_ready = 0, cfg_done = 0, cfg_error = 0.
- All data_*_out = 0.

Handshake:
- A word transfers on a rising edge when cfg_valid && cfg_ready.
- cfg_valid may drop at any time; no transfer happens without ready.

Shift chain:
- Each transfer during LOAD: chain <= {cfg_data, chain[CHAIN_W-1:CFG_WORD_W]}, checksum ^= cfg_data, counter++.
- After WORDS transfers, word 0 sits at bits [CFG_WORD_W-1:0].
- Column c config = chain[c*COL_CFG_W +: COL_CFG_W].
- Chain bits at or above TOTAL are padding and ignored, but still included in the checksum.

States:
- IDLE: cfg_ready = 0. cfg_start -> LOAD.
- LOAD: cfg_ready = 1. On entry, counter and checksum clear to 0. After the WORDS-th transfer -> CHECK.
- CHECK: cfg_ready = 1; this state accepts exactly one word, and the chain does not shift.
  - Word == checksum -> DONE.
  - Word != checksum -> ERROR.
- DONE: cfg_done = 1, cfg_ready = 0.
- ERROR: cfg_error = 1, cfg_ready = 0. The chain keeps its contents; the fabric stays held.
- cfg_start in any state (including LOAD, CHECK, DONE, ERROR) -> LOAD the next cycle:
  - counter and checksum clear;
  - cfg_done and cfg_error drop to 0.
- cfg_start takes priority over a same-cycle transfer; that word is discarded.

Fabric hold:
- Each column's reset input is asserted whenever reset is high or state != DONE.
- In DONE only, data_*_out pass column outputs combinationally; otherwise they are 0.
- Latency from the checksum-word edge to cfg_done = 1: one cycle, and the fabric is released on that same edge.

Reset mid-load:
- Asynchronous return to the reset values above. A partial chain is discarded (cleared to 0).

Optional Feature:
- Macro CFG_READBACK_EN.

With the macro defined:
- Adds ports rb_start (in, 1), rb_data (out, CFG_WORD_W), rb_valid (out, 1) and rb_ready (in, 1).
- rb_start in DONE -> state READBACK; the fabric is held exactly as in LOAD.
- In READBACK:
  - rb_data = chain[CFG_WORD_W-1:0] and rb_valid = 1.
  - On each rb_valid && rb_ready, the chain rotates right by CFG_WORD_W.
- After WORDS rotations the chain is restored and the state returns to DONE.
- rb_start outside DONE is ignored; cfg_start during READBACK -> LOAD.
- All rb outputs reset to 0.

Without the macro:
- No rb ports and no READBACK state.

Decomposition:
- Package logic_grid_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, DONE, ERROR, READBACK);
  - functions for WORDS and CHAIN_W.
- Sub-module cfg_chain_loader: FSM, counter, checksum and shift chain, exporting the TOTAL-bit config and a fabric_hold signal.
- The top level holds the loader plus a generate loop of logic_column instances. The east-west links are internal wires between adjacent columns, each EW_IO bits.

Test Plan:
1. Small config (NUM_COLUMNS=1, COL_CFG_W=40, CFG_WORD_W=16; WORDS=3): send 0x1234, 0xABCD, 0x00FF, then checksum 0xB906.
   - Required: cfg_done = 1 exactly one cycle after the checksum transfer.
   - Required: column config = 0xFFABCD1234 (top 8 padding bits 0x00 dropped).
2. Same words with a bad checksum 0xB907.
   - Required: cfg_error = 1, cfg_done = 0, all data_*_out = 0.
   - Then cfg_start plus a good sequence -> cfg_done = 1 and cfg_error = 0.
3. Default parameters (WORDS=55, 14 padding bits): random stream with cfg_valid toggled 50% of cycles.
   - Required: column c config equals the model slice; transfers occur only when valid && ready.
4. cfg_start after word 2 of 3 in a load, asserted together with a valid word.
   - Required: that word is dropped and the counter restarts; a fresh 3 words plus checksum -> cfg_done = 1.
5. reset asserted mid-LOAD with no clock edge.
   - Required: cfg_ready, cfg_done and data_*_out go to 0 immediately.
   - Required after release: IDLE, chain 0.
6. With CFG_READBACK_EN, after case 1: rb_start with rb_ready held high.
   - Required: rb_data = 0x1234, 0xABCD, 0x00FF on three consecutive cycles, then DONE with the config unchanged.
